// File: rtl/wb_bus_watchdog_pkg.sv
// Shared types and helpers for the Wishbone bus watchdog stage.
package wb_bus_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } wd_state_t;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Bits needed to count 0 .. n-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_bus_watchdog_fault_log.sv
// Sticky timeout flag plus optional address/we/count log.
// Log registers are built only with WB_BUS_WATCHDOG_FAULT_LOG_EN defined.
module wb_bus_watchdog_fault_log
    import wb_bus_watchdog_pkg::*;
#(
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              timeout,
    input  logic              clr,
    input  logic [31:0]       adr,
    input  logic              we,
    output logic              fault,
    output logic [31:0]       fault_adr,
    output logic              fault_we,
    output logic [FCNT_W-1:0] fault_cnt
);

    // A timeout in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (timeout) begin
            fault <= 1'b1;
        end else if (clr) begin
            fault <= 1'b0;
        end
    end

`ifdef WB_BUS_WATCHDOG_FAULT_LOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_adr <= '0;
            fault_we  <= 1'b0;
            fault_cnt <= '0;
        end else if (timeout) begin
            fault_adr <= adr;
            fault_we  <= we;
            // Clear and timeout together restart the count at one.
            if (clr) begin
                fault_cnt <= FCNT_W'(1);
            end else if (fault_cnt != '1) begin
                fault_cnt <= fault_cnt + FCNT_W'(1);
            end
        end else if (clr) begin
            fault_adr <= '0;
            fault_we  <= 1'b0;
            fault_cnt <= '0;
        end
    end
`else
    logic unused_log_inputs;

    assign unused_log_inputs = ^{adr, we};
    assign fault_adr         = '0;
    assign fault_we          = 1'b0;
    assign fault_cnt         = '0;
`endif

endmodule

// File: rtl/wb_bus_watchdog.sv
// Wishbone pipeline stage that force-terminates cycles the decoder never ACKs.
// Optional fault log: define WB_BUS_WATCHDOG_FAULT_LOG_EN.
module wb_bus_watchdog
    import wb_bus_watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT,
    parameter int unsigned FCNT_W         = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m_cyc_i,
    input  logic              m_stb_i,
    input  logic              m_we_i,
    input  logic [31:0]       m_adr_i,
    input  logic [31:0]       m_dat_i,
    input  logic [3:0]        m_sel_i,
    output logic              m_ack_o,
    output logic [31:0]       m_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [31:0]       s_adr_o,
    output logic [31:0]       s_dat_o,
    output logic [3:0]        s_sel_o,
    input  logic              s_ack_i,
    input  logic [31:0]       s_dat_i,
    output logic              fault_o,
    input  logic              fault_clr_i,
    output logic [31:0]       fault_adr_o,
    output logic              fault_we_o,
    output logic [FCNT_W-1:0] fault_cnt_o
);

    localparam int unsigned      TMR_W    = clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    wd_state_t        state;
    logic [TMR_W-1:0] timer;
    logic             timeout;

    // An ACK on the last permitted cycle still counts as a normal completion.
    assign timeout = (state == BUSY) && !s_ack_i && (timer == TMR_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            timer   <= '0;
            m_ack_o <= 1'b0;
            m_dat_o <= '0;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            s_we_o  <= 1'b0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
        end else begin
            m_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_we_o  <= m_we_i;
                        s_adr_o <= m_adr_i;
                        s_dat_o <= m_dat_i;
                        s_sel_o <= m_sel_i;
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        timer   <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer + TMR_W'(1);
                    if (s_ack_i) begin
                        m_dat_o <= s_dat_i;
                        m_ack_o <= 1'b1;
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        state   <= RESP;
                    end else if (timer == TMR_LAST) begin
                        m_dat_o <= TIMEOUT_DATA;
                        m_ack_o <= 1'b1;
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        state   <= RESP;
                    end else if (!m_cyc_i) begin
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    wb_bus_watchdog_fault_log #(
        .FCNT_W(FCNT_W)
    ) u_fault_log (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .timeout  (timeout),
        .clr      (fault_clr_i),
        .adr      (s_adr_o),
        .we       (s_we_o),
        .fault    (fault_o),
        .fault_adr(fault_adr_o),
        .fault_we (fault_we_o),
        .fault_cnt(fault_cnt_o)
    );

endmodule
